mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/mem_timeout_ctr.sv | 34 +++
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, widths and mem_stage state encoding
// Contents: ALU opcode constants, data/register-index widths, mem_stage FSM
// state type, memory-access timeout limit.
package pipeline_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    localparam logic [1:0] ALU_OP_AND = 2'd0;
    localparam logic [1:0] ALU_OP_ADD = 2'd1;
    localparam logic [1:0] ALU_OP_SUB = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    localparam int MEM_TIMEOUT_LIMIT = 16;
    localparam int MEM_TIMEOUT_W     = 5;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - counts memory-access cycles without acknowledge
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   active      - the stage is waiting on memory this cycle
//   ack         - memory acknowledged this cycle
//   expired     - this is the LIMIT-th consecutive unacknowledged access cycle
module mem_timeout_ctr
    import pipeline_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic expired
);

    logic [MEM_TIMEOUT_W-1:0] cnt;

    // cnt holds the number of unacknowledged access cycles already elapsed,
    // so the current cycle is the LIMIT-th one when cnt == LIMIT-1.
    assign expired = active && !ack &&
                     (cnt == MEM_TIMEOUT_W'(MEM_TIMEOUT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!active || ack || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + MEM_TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: passes ALU results, performs loads/stores
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   in_valid, alu_result, store_data - execute-stage result
//   mem_read, mem_write, rd, reg_write, flush
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack - memory port
//   stall                            - upstream must hold while high
//   wb_valid, wb_reg_write, wb_rd, wb_data - writeback result
//   mem_err                          - sticky timeout flag (MEM_STAGE_TIMEOUT_EN only)
// Optional feature: define MEM_STAGE_TIMEOUT_EN to abort accesses that
// receive no mem_ack within MEM_TIMEOUT_LIMIT cycles.
module mem_stage
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [REG_W-1:0]  rd,
    input  logic              reg_write,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    mem_state_t state, state_next;

    logic             lat_load;
    logic             lat_reg_write;
    logic [REG_W-1:0] lat_rd;

    logic accept_alu;
    logic accept_mem;
    logic retire_mem;
    logic timeout_hit;

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_timeout_ctr u_timeout (
        .clk     (clk),
        .reset   (reset),
        .active  (state == ST_ACCESS),
        .ack     (mem_ack),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_alu = 1'b0;
        accept_mem = 1'b0;
        retire_mem = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    if (mem_read || mem_write) begin
                        accept_mem = 1'b1;
                        state_next = ST_ACCESS;
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // flush is deliberately ignored here: the access must complete.
                if (mem_ack) begin
                    retire_mem = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign stall   = (state == ST_ACCESS);
    assign mem_req = (state == ST_ACCESS);
    assign mem_we  = (state == ST_ACCESS) && !lat_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            lat_load      <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_rd        <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (accept_alu) begin
                wb_valid     <= 1'b1;
                wb_data      <= alu_result;
                wb_rd        <= rd;
                wb_reg_write <= reg_write;
            end
            if (accept_mem) begin
                mem_addr      <= alu_result;
                mem_wdata     <= store_data;
                lat_rd        <= rd;
                lat_reg_write <= reg_write;
                // Both flags set resolves to a load.
                lat_load      <= mem_read;
            end
            if (retire_mem) begin
                wb_valid <= 1'b1;
                wb_rd    <= lat_rd;
                if (lat_load) begin
                    wb_data      <= mem_rdata;
                    wb_reg_write <= lat_reg_write;
                end else begin
                    wb_reg_write <= 1'b0;
                end
            end else if (timeout_hit) begin
                wb_valid     <= 1'b1;
                wb_rd        <= lat_rd;
                wb_reg_write <= 1'b0;
            end
        end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else if (timeout_hit) begin
            mem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  rd;
    logic        reg_write;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
`ifdef MEM_STAGE_TIMEOUT_EN
    logic        mem_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int stall_cycles;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .rd           (rd),
        .reg_write    (reg_write),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
`ifdef MEM_STAGE_TIMEOUT_EN
        ,
        .mem_err      (mem_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wb_valid"},     32'(wb_valid),     32'd0);
        check({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'd0);
        check({tag, ".wb_rd"},        32'(wb_rd),        32'd0);
        check({tag, ".wb_data"},      32'(wb_data),      32'd0);
        check({tag, ".mem_req"},      32'(mem_req),      32'd0);
        check({tag, ".mem_we"},       32'(mem_we),       32'd0);
        check({tag, ".mem_addr"},     32'(mem_addr),     32'd0);
        check({tag, ".mem_wdata"},    32'(mem_wdata),    32'd0);
        check({tag, ".stall"},        32'(stall),        32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; rd = '0; reg_write = 1'b0;
        flush = 1'b0; mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check_all_zero("reset");

        // Non-memory op, 1-cycle latency, no stall
        in_valid = 1'b1; alu_result = 16'h001E; rd = 3'd3; reg_write = 1'b1;
        tick();
        in_valid = 1'b0;
        check("alu.wb_valid", 32'(wb_valid), 32'd1);
        check("alu.wb_data",  32'(wb_data),  32'h001E);
        check("alu.wb_rd",    32'(wb_rd),    32'd3);
        check("alu.wb_rw",    32'(wb_reg_write), 32'd1);
        check("alu.stall",    32'(stall),    32'd0);
        tick();
        check("alu.pulse",    32'(wb_valid), 32'd0);
        check("alu.hold",     32'(wb_data),  32'h001E);

        // Load from 0x0040, ack after 3 waiting cycles
        in_valid = 1'b1; mem_read = 1'b1; alu_result = 16'h0040; rd = 3'd5; reg_write = 1'b1;
        tick();
        in_valid = 1'b0; mem_read = 1'b0;
        stall_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            if (stall) stall_cycles++;
            check("ld.mem_req",  32'(mem_req),  32'd1);
            check("ld.mem_addr", 32'(mem_addr), 32'h0040);
            check("ld.mem_we",   32'(mem_we),   32'd0);
            check("ld.no_wb",    32'(wb_valid), 32'd0);
            tick();
        end
        if (stall) stall_cycles++;
        check("ld.ack_addr", 32'(mem_addr), 32'h0040);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("ld.stall_cnt", 32'(stall_cycles), 32'd4);
        check("ld.wb_valid",  32'(wb_valid), 32'd1);
        check("ld.wb_data",   32'(wb_data),  32'hBEEF);
        check("ld.wb_rd",     32'(wb_rd),    32'd5);
        check("ld.wb_rw",     32'(wb_reg_write), 32'd1);
        check("ld.idle_stall", 32'(stall),   32'd0);
        check("ld.idle_req",  32'(mem_req),  32'd0);

        // Store 0x1234 to 0x0010, ack on first access cycle
        in_valid = 1'b1; mem_write = 1'b1; alu_result = 16'h0010; store_data = 16'h1234;
        rd = 3'd2; reg_write = 1'b1;
        tick();
        in_valid = 1'b0; mem_write = 1'b0;
        check("st.mem_req",   32'(mem_req),   32'd1);
        check("st.mem_we",    32'(mem_we),    32'd1);
        check("st.mem_addr",  32'(mem_addr),  32'h0010);
        check("st.mem_wdata", 32'(mem_wdata), 32'h1234);
        check("st.stall",     32'(stall),     32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st.wb_valid",  32'(wb_valid),     32'd1);
        check("st.wb_rw",     32'(wb_reg_write), 32'd0);
        check("st.data_hold", 32'(wb_data),      32'hBEEF);
        check("st.we_idle",   32'(mem_we),       32'd0);

        // Flush in IDLE suppresses both ALU and memory ops
        in_valid = 1'b1; flush = 1'b1; alu_result = 16'h0077; rd = 3'd6; reg_write = 1'b1;
        tick();
        check("fl.alu_wb",    32'(wb_valid), 32'd0);
        check("fl.alu_hold",  32'(wb_data),  32'hBEEF);
        mem_read = 1'b1;
        tick();
        in_valid = 1'b0; mem_read = 1'b0; flush = 1'b0;
        check("fl.mem_stall", 32'(stall),    32'd0);
        check("fl.mem_wb",    32'(wb_valid), 32'd0);

        // Flush during pending load is ignored
        in_valid = 1'b1; mem_read = 1'b1; alu_result = 16'h0022; rd = 3'd1; reg_write = 1'b1;
        tick();
        in_valid = 1'b0; mem_read = 1'b0; flush = 1'b1;
        tick();
        check("flp.stall",    32'(stall),    32'd1);
        check("flp.addr",     32'(mem_addr), 32'h0022);
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        tick();
        mem_ack = 1'b0; flush = 1'b0;
        check("flp.wb_valid", 32'(wb_valid), 32'd1);
        check("flp.wb_data",  32'(wb_data),  32'h5A5A);
        check("flp.wb_rd",    32'(wb_rd),    32'd1);

        // Both flags set behaves as a load
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; alu_result = 16'h0033;
        store_data = 16'hAAAA; rd = 3'd4; reg_write = 1'b1;
        tick();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        check("both.mem_we",  32'(mem_we),   32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        tick();
        mem_ack = 1'b0;
        check("both.wb_data", 32'(wb_data),  32'h0F0F);
        check("both.wb_rw",   32'(wb_reg_write), 32'd1);
        check("both.wb_rd",   32'(wb_rd),    32'd4);

        // mem_ack in IDLE ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack.wb",  32'(wb_valid), 32'd0);
        check("idle_ack.req", 32'(mem_req),  32'd0);

        // Reset mid-access, then stray ack
        in_valid = 1'b1; mem_read = 1'b1; alu_result = 16'h0055; rd = 3'd7; reg_write = 1'b1;
        tick();
        in_valid = 1'b0; mem_read = 1'b0;
        check("rst.in_access", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("rst");
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        check("rst.stray_wb",   32'(wb_valid), 32'd0);
        check("rst.stray_data", 32'(wb_data),  32'd0);
        check("rst.stray_stall", 32'(stall),   32'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
        // Timeout: 16 unacknowledged access cycles
        in_valid = 1'b1; mem_read = 1'b1; alu_result = 16'h0099; rd = 3'd2; reg_write = 1'b1;
        tick();
        in_valid = 1'b0; mem_read = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        check("to.before",    32'(mem_err),  32'd0);
        tick();
        check("to.wb_valid",  32'(wb_valid), 32'd1);
        check("to.wb_rw",     32'(wb_reg_write), 32'd0);
        check("to.mem_err",   32'(mem_err),  32'd1);
        check("to.idle",      32'(stall),    32'd0);
        tick(); tick();
        check("to.sticky",    32'(mem_err),  32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("to.cleared",   32'(mem_err),  32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
